// File: rtl/deserializer4bit.sv
// deserializer4bit: serial-in/parallel-out receiver for LSB-first frames
// (start bit 0, WIDTH data bits, stop bit 1). The line is synchronized,
// each bit is sampled once per bit period after a mid-start alignment,
// and good words are presented on p_out with a one-cycle valid strobe.
module deserializer4bit #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_in,
  output logic [WIDTH-1:0] p_out,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // H is the mid-bit offset; with one clock per bit it collapses to zero
  localparam logic [CNT_W-1:0] H_CNT    = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sh;
  logic             sync1;
  logic             s_sync;

  // Two-flop synchronizer; both stages reset to the idle-high line level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      s_sync <= 1'b1;
    end else begin
      sync1  <= s_in;
      s_sync <= sync1;
    end
  end

  // Receive FSM: start detect, mid-start check, per-bit sampling, stop check
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      p_out     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!s_sync) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == H_CNT) begin
            cnt <= '0;
            idx <= '0;
            // A start bit that has vanished by mid-bit is a glitch, not a frame
            state <= s_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            sh  <= (sh >> 1) | (WIDTH'(s_sync) << (WIDTH - 1));
            if (idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (s_sync) begin
              p_out <= sh;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Stay here while the line is held low so it cannot re-trigger
          if (s_sync) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_deserializer4bit.sv
// tb_deserializer4bit: scoreboard bench for deserializer4bit. Each frame
// driven pushes its expected outcome (word or framing error, plus the cycle
// on which the pulse must appear); a monitor pops and compares on pulses.
module tb_deserializer4bit;

  localparam int WIDTH        = 4;
  localparam int CLKS_PER_BIT = 4;
  localparam int H            = (CLKS_PER_BIT - 1) / 2;
  // Cycles from driving the start bit to seeing the pulse: 1 to be sampled,
  // 2 through the synchronizer, H+1 to mid-start, WIDTH+1 bit periods after
  localparam int LATENCY = 1 + 2 + H + 1 + (WIDTH + 1) * CLKS_PER_BIT;

  typedef struct {
    logic [31:0] data;
    logic        is_err;
    int          cycle;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic             s_in;
  logic [WIDTH-1:0] p_out;
  logic             valid;
  logic             frame_err;
  logic             busy;

  exp_t        sb[$];
  exp_t        e;
  int          cycle;
  int          tests_run;
  int          tests_failed;
  logic [31:0] last_good;
  int          busy_seen;

  deserializer4bit #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_in(s_in),
    .p_out(p_out),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to time-stamp pulses
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Drive one whole frame starting at a negedge and record what it should yield
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic stop_bit);
    exp_t x;
    x.data   = 32'(data);
    x.is_err = ~stop_bit;
    x.cycle  = cycle + LATENCY;
    sb.push_back(x);
    s_in = 1'b0;
    repeat (CLKS_PER_BIT) @(negedge clk);
    for (int b = 0; b < WIDTH; b++) begin
      s_in = data[b];
      repeat (CLKS_PER_BIT) @(negedge clk);
    end
    s_in = stop_bit;
    repeat (CLKS_PER_BIT) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest scoreboard entry
  always @(negedge clk) begin
    if (reset_n) begin
      if (valid && frame_err) checkOutput("both_pulses", 32'd1, 32'd0);
      if (valid || frame_err) begin
        if (sb.size() == 0) begin
          checkOutput(valid ? "unexpected_valid" : "unexpected_ferr", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind", 32'(frame_err), 32'(e.is_err));
          checkOutput("pulse_cycle", 32'(cycle), 32'(e.cycle));
          if (valid) begin
            checkOutput("p_out_word", 32'(p_out), e.data);
            checkOutput("busy_after_stop", 32'(busy), 32'd0);
            last_good = e.data;
          end else begin
            checkOutput("p_out_hold_on_err", 32'(p_out), last_good);
          end
        end
      end
    end
  end

  // Main stimulus sequence
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cycle        = 0;
    last_good    = '0;
    s_in         = 1'b1;
    reset_n      = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_p_out", 32'(p_out), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_ferr", 32'(frame_err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Single good frame, then back-to-back frames
    applyStimulus(4'hB, 1'b1);
    repeat (6) @(negedge clk);
    applyStimulus(4'hB, 1'b1);
    applyStimulus(4'h4, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("b2b_p_out", 32'(p_out), 32'h4);

    // One-cycle glitch must be rejected silently
    s_in = 1'b0;
    @(negedge clk);
    s_in = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    checkOutput("glitch_busy_seen", 32'(busy_seen != 0), 32'd1);
    checkOutput("glitch_back_idle", 32'(busy), 32'd0);

    // Framing error followed by a held-low line
    applyStimulus(4'h5, 1'b0);
    repeat (10 * CLKS_PER_BIT) @(negedge clk);
    checkOutput("break_busy", 32'(busy), 32'd1);
    checkOutput("break_p_out", 32'(p_out), 32'h4);
    s_in = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("break_exit", 32'(busy), 32'd0);
    applyStimulus(4'hA, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("after_err_p_out", 32'(p_out), 32'hA);

    // Reset in the middle of data bit 2
    s_in = 1'b0;
    repeat (CLKS_PER_BIT) @(negedge clk);
    s_in = 1'b1;
    repeat (2 * CLKS_PER_BIT) @(negedge clk);
    s_in = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_p_out", 32'(p_out), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_valid", 32'(valid), 32'd0);
    checkOutput("midreset_ferr", 32'(frame_err), 32'd0);
    last_good = '0;
    @(negedge clk);
    @(negedge clk);
    s_in    = 1'b1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(4'h7, 1'b1);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    checkOutput("final_p_out", 32'(p_out), 32'h7);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
